// File: rtl/id_stage_if.sv
// Fetch/write-back/hazard side of the decode stage, bundled for one port.
// slave is the decode stage itself; master is whoever drives it (fetch, WB,
// hazard sources, or a bench).
interface id_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // from fetch / WB / later stages
  logic [DATA_WIDTH-1:0]     i_pc_plus_4;
  logic [DATA_WIDTH-1:0]     i_instruction;
  logic                      i_wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] i_wb_write_reg;
  logic [DATA_WIDTH-1:0]     i_wb_write_data;
  logic                      i_ex_mem_read;
  logic                      i_ex_reg_write;
  logic [REG_ADDR_WIDTH-1:0] i_ex_write_reg;
  logic                      i_mem_mem_read;
  logic [REG_ADDR_WIDTH-1:0] i_mem_write_reg;
  // to fetch
  logic                      o_stall;
  logic                      o_pcsrc;
  logic                      o_jump;
  logic [DATA_WIDTH-1:0]     o_beq_dir;
  logic [DATA_WIDTH-1:0]     o_jmp_dir;
  // to ID/EX
  logic                      o_valid;
  logic [DATA_WIDTH-1:0]     o_pc_plus_4;
  logic [DATA_WIDTH-1:0]     o_read_data_1;
  logic [DATA_WIDTH-1:0]     o_read_data_2;
  logic [DATA_WIDTH-1:0]     o_sign_ext_imm;
  logic [5:0]                o_opcode;
  logic [5:0]                o_funct;
  logic [REG_ADDR_WIDTH-1:0] o_rs;
  logic [REG_ADDR_WIDTH-1:0] o_rt;
  logic [REG_ADDR_WIDTH-1:0] o_rd;
  logic [REG_ADDR_WIDTH-1:0] o_shamt;

  modport slave (
    input  i_pc_plus_4, i_instruction, i_wb_reg_write, i_wb_write_reg,
           i_wb_write_data, i_ex_mem_read, i_ex_reg_write, i_ex_write_reg,
           i_mem_mem_read, i_mem_write_reg,
    output o_stall, o_pcsrc, o_jump, o_beq_dir, o_jmp_dir, o_valid,
           o_pc_plus_4, o_read_data_1, o_read_data_2, o_sign_ext_imm,
           o_opcode, o_funct, o_rs, o_rt, o_rd, o_shamt
  );

  modport master (
    output i_pc_plus_4, i_instruction, i_wb_reg_write, i_wb_write_reg,
           i_wb_write_data, i_ex_mem_read, i_ex_reg_write, i_ex_write_reg,
           i_mem_mem_read, i_mem_write_reg,
    input  o_stall, o_pcsrc, o_jump, o_beq_dir, o_jmp_dir, o_valid,
           o_pc_plus_4, o_read_data_1, o_read_data_2, o_sign_ext_imm,
           o_opcode, o_funct, o_rs, o_rt, o_rd, o_shamt
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, 32-entry register file with WB bypass,
// load-use / branch-operand hazard detection, and BEQ/BNE/J/JAL resolution.
module id_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic    i_clk,
  input  logic    i_reset,
  id_stage_if.slave bus
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [DATA_WIDTH-1:0] pc4_q, instr_q;
  logic [DATA_WIDTH-1:0] regs [NREG];

  logic [5:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs, rt;
  logic [DATA_WIDTH-1:0]     read1, read2, sext;
  logic uses_rt, is_branch, load_use, branch_haz, stall, taken, flush;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign sext   = {{(DATA_WIDTH-16){instr_q[15]}}, instr_q[15:0]};

  // Register reads with write-back bypass; r0 is hardwired to zero.
  always_comb begin
    read1 = regs[rs];
    read2 = regs[rt];
    if (bus.i_wb_reg_write && bus.i_wb_write_reg != '0 && bus.i_wb_write_reg == rs)
      read1 = bus.i_wb_write_data;
    if (bus.i_wb_reg_write && bus.i_wb_write_reg != '0 && bus.i_wb_write_reg == rt)
      read2 = bus.i_wb_write_data;
    if (rs == '0) read1 = '0;
    if (rt == '0) read2 = '0;
  end

  // Hazard detection and branch/jump resolution.
  always_comb begin
    uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                (opcode == OP_BNE)   || (opcode == OP_SW);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    load_use  = bus.i_ex_mem_read && bus.i_ex_write_reg != '0 &&
                (bus.i_ex_write_reg == rs || (uses_rt && bus.i_ex_write_reg == rt));
    // Branches compare in ID, so any in-flight producer of an operand stalls.
    branch_haz = is_branch &&
      ((bus.i_ex_reg_write && bus.i_ex_write_reg != '0 &&
        (bus.i_ex_write_reg == rs || bus.i_ex_write_reg == rt)) ||
       (bus.i_mem_mem_read && bus.i_mem_write_reg != '0 &&
        (bus.i_mem_write_reg == rs || bus.i_mem_write_reg == rt)));
    stall = load_use || branch_haz;
    taken = 1'b0;
    if (opcode == OP_BEQ) taken = (read1 == read2);
    if (opcode == OP_BNE) taken = (read1 != read2);
  end

  assign bus.o_stall   = stall;
  assign bus.o_valid   = !stall;
  assign bus.o_pcsrc   = taken && !stall;
  assign bus.o_jump    = (opcode == OP_J || opcode == OP_JAL) && !stall;
  assign bus.o_beq_dir = pc4_q + {sext[DATA_WIDTH-3:0], 2'b00};
  assign bus.o_jmp_dir = {pc4_q[DATA_WIDTH-1:DATA_WIDTH-4], instr_q[25:0], 2'b00};
  assign flush         = bus.o_pcsrc || bus.o_jump;

  assign bus.o_pc_plus_4    = pc4_q;
  assign bus.o_read_data_1  = read1;
  assign bus.o_read_data_2  = read2;
  assign bus.o_sign_ext_imm = sext;
  assign bus.o_opcode       = opcode;
  assign bus.o_funct        = instr_q[5:0];
  assign bus.o_rs           = rs;
  assign bus.o_rt           = rt;
  assign bus.o_rd           = instr_q[15:11];
  assign bus.o_shamt        = instr_q[10:6];

  // IF/ID register: stall holds, a resolved branch/jump squashes to NOP.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc4_q   <= '0;
      instr_q <= '0;
    end else if (!stall) begin
      if (flush) begin
        pc4_q   <= '0;
        instr_q <= '0;
      end else begin
        pc4_q   <= bus.i_pc_plus_4;
        instr_q <= bus.i_instruction;
      end
    end
  end

  // Register file write port; writes to r0 are dropped.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.i_wb_reg_write && bus.i_wb_write_reg != '0) begin
      regs[bus.i_wb_write_reg] <= bus.i_wb_write_data;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
  id_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic stall, pcsrc, jump, valid;
    logic [31:0] beq_dir, jmp_dir, pc4, rd1, rd2, imm;
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, shamt;
  } out_t;

  typedef struct {
    logic [31:0] pc4, instr;
    logic wb_we; logic [4:0] wb_reg; logic [31:0] wb_data;
    logic ex_mr, ex_rw; logic [4:0] ex_wr;
    logic mem_mr; logic [4:0] mem_wr;
  } stim_t;

  int tests = 0;
  int fails = 0;
  out_t q[$];

  // reference state
  logic [31:0] m_pc4, m_instr;
  logic [31:0] m_regs [32];

  function automatic stim_t idle();
    stim_t s;
    s.pc4 = 32'h0; s.instr = 32'h0;
    s.wb_we = 0; s.wb_reg = 0; s.wb_data = 0;
    s.ex_mr = 0; s.ex_rw = 0; s.ex_wr = 0;
    s.mem_mr = 0; s.mem_wr = 0;
    return s;
  endfunction

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] mread(stim_t s, logic [4:0] a);
    if (a == 0) return 32'h0;
    if (s.wb_we && s.wb_reg == a) return s.wb_data;
    return m_regs[a];
  endfunction

  // Expected outputs derived from the decode/hazard rules.
  function automatic out_t model_out(stim_t s);
    out_t o;
    int op, imm;
    logic [4:0] rs, rt;
    logic uses_rt, br, lu, bh;
    op  = int'(m_instr[31:26]);
    rs  = m_instr[25:21];
    rt  = m_instr[20:16];
    imm = int'($signed(m_instr[15:0]));
    o.op = m_instr[31:26]; o.rs = rs; o.rt = rt; o.rd = m_instr[15:11];
    o.shamt = m_instr[10:6]; o.funct = m_instr[5:0];
    o.imm = 32'(imm);
    o.pc4 = m_pc4;
    o.rd1 = mread(s, rs);
    o.rd2 = mread(s, rt);
    uses_rt = (op == 0 || op == 4 || op == 5 || op == 'h2B);
    br = (op == 4 || op == 5);
    lu = s.ex_mr && s.ex_wr != 0 && (s.ex_wr == rs || (uses_rt && s.ex_wr == rt));
    bh = br && ((s.ex_rw && s.ex_wr != 0 && (s.ex_wr == rs || s.ex_wr == rt)) ||
                (s.mem_mr && s.mem_wr != 0 && (s.mem_wr == rs || s.mem_wr == rt)));
    o.stall = lu || bh;
    o.valid = !o.stall;
    o.pcsrc = !o.stall && ((op == 4 && o.rd1 == o.rd2) || (op == 5 && o.rd1 != o.rd2));
    o.jump  = !o.stall && (op == 2 || op == 3);
    o.beq_dir = m_pc4 + 32'(imm * 4);
    o.jmp_dir = (m_pc4 & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
    return o;
  endfunction

  task automatic model_edge(stim_t s, out_t o);
    if (s.wb_we && s.wb_reg != 0) m_regs[s.wb_reg] = s.wb_data;
    if (!o.stall) begin
      if (o.pcsrc || o.jump) begin m_pc4 = 0; m_instr = 0; end
      else begin m_pc4 = s.pc4; m_instr = s.instr; end
    end
  endtask

  task automatic model_clear();
    m_pc4 = 0; m_instr = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  function automatic out_t sample();
    out_t a;
    a.stall = bus.o_stall; a.pcsrc = bus.o_pcsrc; a.jump = bus.o_jump;
    a.valid = bus.o_valid; a.beq_dir = bus.o_beq_dir; a.jmp_dir = bus.o_jmp_dir;
    a.pc4 = bus.o_pc_plus_4; a.rd1 = bus.o_read_data_1; a.rd2 = bus.o_read_data_2;
    a.imm = bus.o_sign_ext_imm; a.op = bus.o_opcode; a.funct = bus.o_funct;
    a.rs = bus.o_rs; a.rt = bus.o_rt; a.rd = bus.o_rd; a.shamt = bus.o_shamt;
    return a;
  endfunction

  task automatic drive(stim_t s);
    bus.i_pc_plus_4 = s.pc4; bus.i_instruction = s.instr;
    bus.i_wb_reg_write = s.wb_we; bus.i_wb_write_reg = s.wb_reg;
    bus.i_wb_write_data = s.wb_data;
    bus.i_ex_mem_read = s.ex_mr; bus.i_ex_reg_write = s.ex_rw;
    bus.i_ex_write_reg = s.ex_wr;
    bus.i_mem_mem_read = s.mem_mr; bus.i_mem_write_reg = s.mem_wr;
  endtask

  // One cycle: drive just after the edge, queue expectation, advance model.
  task automatic step(stim_t s);
    out_t e;
    @(posedge clk); #1;
    drive(s);
    e = model_out(s);
    q.push_back(e);
    model_edge(s, e);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      out_t e, a;
      e = q.pop_front();
      a = sample();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got %h expected %h", $time, a, e);
      end
    end
  end

  logic [5:0] ops [8] = '{6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h2B, 6'h0F};

  initial begin
    stim_t s;
    out_t z;
    z = '0; z.valid = 1'b1;
    model_clear();
    drive(idle());
    #12;
    tests++;
    if (sample() !== z) begin
      fails++; $display("FAIL reset_state got %h expected %h", sample(), z);
    end
    @(negedge clk); rst_n = 1'b1;

    // preload r1=r2=5
    s = idle(); s.wb_we = 1; s.wb_reg = 1; s.wb_data = 5; step(s);
    s = idle(); s.wb_we = 1; s.wb_reg = 2; s.wb_data = 5; step(s);

    // BEQ taken: beq r1,r2,-1 at pc4=0x10
    s = idle(); s.pc4 = 32'h10; s.instr = itype(4, 1, 2, -1); step(s);
    s = idle(); s.pc4 = 32'h14; s.instr = rtype(1, 2, 3, 'h20); step(s);
    chk("beq_pcsrc", 32'(bus.o_pcsrc), 1);
    chk("beq_dir", bus.o_beq_dir, 32'h0C);
    s = idle(); step(s);
    chk("beq_flush_op", 32'(bus.o_opcode), 0);
    chk("beq_flush_pc4", bus.o_pc_plus_4, 0);

    // BNE not taken with WB bypass on r5
    s = idle(); s.wb_we = 1; s.wb_reg = 6; s.wb_data = 7; step(s);
    s = idle(); s.pc4 = 32'h30; s.instr = itype(5, 5, 6, 4); step(s);
    s = idle(); s.wb_we = 1; s.wb_reg = 5; s.wb_data = 7; step(s);
    chk("bne_pcsrc", 32'(bus.o_pcsrc), 0);
    s = idle(); s.pc4 = 32'h38; s.instr = rtype(5, 0, 7, 'h20); step(s);
    s = idle(); step(s);
    chk("r5_held", bus.o_read_data_1, 7);

    // Jump
    s = idle(); s.pc4 = 32'h4000_0010; s.instr = {6'd2, 26'h0100}; step(s);
    s = idle(); s.pc4 = 32'h4000_0014; s.instr = rtype(1, 1, 1, 0); step(s);
    chk("j_jump", 32'(bus.o_jump), 1);
    chk("j_dir", bus.o_jmp_dir, 32'h4000_0400);
    s = idle(); step(s);
    chk("j_flush_pc4", bus.o_pc_plus_4, 0);

    // Load-use: lw r2 in EX, add r3,r2,r4 in ID
    s = idle(); s.pc4 = 32'h20; s.instr = rtype(2, 4, 3, 'h20); step(s);
    s = idle(); s.pc4 = 32'h24; s.instr = rtype(8, 8, 8, 0);
    s.ex_mr = 1; s.ex_wr = 2; step(s);
    chk("lu_stall", 32'(bus.o_stall), 1);
    chk("lu_valid", 32'(bus.o_valid), 0);
    s = idle(); s.pc4 = 32'h24; s.instr = rtype(8, 8, 8, 0); step(s);
    chk("lu_release", 32'(bus.o_stall), 0);
    chk("lu_hold_pc4", bus.o_pc_plus_4, 32'h20);

    // Branch after load: beq r9,r0 (both 0) with MEM loading r9
    s = idle(); s.pc4 = 32'h50; s.instr = itype(4, 9, 0, 3); step(s);
    s = idle(); s.mem_mr = 1; s.mem_wr = 9; step(s);
    chk("bl_stall", 32'(bus.o_stall), 1);
    chk("bl_pcsrc", 32'(bus.o_pcsrc), 0);
    s = idle(); step(s);

    // r0 write ignored, including the bypass path
    s = idle(); s.pc4 = 32'h60; s.instr = rtype(0, 0, 1, 'h20); step(s);
    s = idle(); s.wb_we = 1; s.wb_reg = 0; s.wb_data = 32'hFFFF_FFFF; step(s);
    chk("r0_bypass", bus.o_read_data_1, 0);
    s = idle(); step(s);
    chk("r0_read", bus.o_read_data_1, 0);

    // Mid-stream reset with a BEQ in IF/ID
    s = idle(); s.pc4 = 32'h70; s.instr = itype(4, 1, 2, 5); step(s);
    @(posedge clk); #1;
    drive(idle());
    rst_n = 1'b0;
    model_clear();
    #1;
    tests++;
    if (sample() !== z) begin
      fails++; $display("FAIL midreset got %h expected %h", sample(), z);
    end
    @(negedge clk); rst_n = 1'b1;
    s = idle(); s.pc4 = 32'h1234; s.instr = rtype(3, 4, 5, 'h22); step(s);
    s = idle(); step(s);
    chk("post_reset_pc4", bus.o_pc_plus_4, 32'h1234);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.pc4   = $urandom & 32'hFFFF_FFFC;
      s.instr = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 16'($urandom)};
      s.wb_we = ($urandom_range(0, 1) == 1);
      s.wb_reg = 5'($urandom_range(0, 7));
      s.wb_data = $urandom;
      s.ex_mr = ($urandom_range(0, 3) == 0);
      s.ex_rw = ($urandom_range(0, 2) == 0);
      s.ex_wr = 5'($urandom_range(0, 7));
      s.mem_mr = ($urandom_range(0, 3) == 0);
      s.mem_wr = 5'($urandom_range(0, 7));
      step(s);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
